seg7_frame_decoder: RTL and testbench
=====================================

// Module: seg7_frame_decoder
// PURPOSE
//  Read-back end of the 7-segment display interface: watches a multiplexed segment bus
//  (seg pattern + one-hot digit select) and reconstructs the displayed multi-digit number.
//  Decodes each stable digit back to BCD using the display encoding table.
//  Assembles a full frame and flags unknown patterns.
//  Sits beside the display driver for score read-back, self-check and simulation monitors.
// PARAMETERS
//  DIGITS         4  number of multiplexed digits (>=1)
//  STABLE_CYCLES  3  consecutive identical samples needed before a digit is accepted (>=1)
// PORTS
//  clk          in   1           system clock
//  rst_n        in   1           async active-low reset
//  seg_in       in   7           segment pattern, bit 6..0, encoding per seg7_pkg table
//  dig_sel      in   DIGITS      one-hot digit select; bit i = digit i (0 = least significant)
//  clear_err    in   1           synchronous clear of err_pattern/err_sel
//  number_out   out  4*DIGITS    decoded frame, nibble i = digit i
//  blank_mask   out  DIGITS      bit i set = digit i was blank (7'b0000000) in frame
//  frame_valid  out  1           1-cycle pulse: number_out/blank_mask updated
//  err_pattern  out  1           sticky: an accepted pattern was not in the table
//  err_sel      out  1           sticky: dig_sel seen with >1 bit set
// BEHAVIOUR
//  - Clock/reset: single clk domain; rst_n asynchronous assert, all state cleared.
//  - Reset values: number_out=0, blank_mask=all 1, frame_valid=0, err_*=0,
//    stable counter=0, capture mask=0.
//  - Stability: register previous (seg_in, dig_sel).
//    - Counter increments (saturating) while the sample equals the previous sample and
//      dig_sel is one-hot; otherwise it reloads to 1 (one-hot) or 0 (not one-hot).
//  - Accept: on the edge where the counter reaches STABLE_CYCLES, the digit is written
//    into shadow slot idx(dig_sel) and capture-mask bit set.
//    - Exactly one accept per dwell; a dwell longer than STABLE_CYCLES does not re-accept.
//  - Decode: 1111110->0, 1100000->1, 1011101->2, 1111001->3, 1100011->4, 0111011->5,
//    0111111->6, 1101000->7, 1111111->8, 1111011->9.
//    - 0000000 -> nibble 4'hF, blank bit set.
//    - Any other pattern -> nibble 4'hE, err_pattern set.
//  - Re-accept of an already captured slot before frame completes: overwrite (latest wins).
//  - Frame complete: when the capture mask becomes all ones (including the accepting
//    edge), the next edge copies shadow -> number_out/blank_mask, pulses frame_valid,
//    and clears the mask.
//    - Total latency: last digit's STABLE_CYCLES-th identical sample + 1 cycle.
//  - dig_sel==0: idle/blanking gap; counter clears; no error.
//  - dig_sel multi-hot: counter clears, err_sel set, no accept.
//  - Sticky errors: clear_err clears both next edge; a same-cycle new error wins (stays 1).
//  - Reset mid-frame: partial shadow/mask discarded; no frame_valid.
// CONFIGURATION
//  SEG7_DEC_CHANGE_ONLY_EN defined:
//    - frame_valid pulses only if the completed frame differs (number or blank mask) from
//      the current number_out/blank_mask; unchanged frames still clear the mask silently.
//    - The first frame after reset always pulses.
//  Undefined: frame_valid pulses on every completed frame.
// STRUCTURE
//  seg7_pkg:
//    - SEG_W=7, DIGIT_BLANK=4'hF, DIGIT_BAD=4'hE.
//    - seg_t typedef; SEG_TABLE[0:9] constant shared with the encoder.
//    - function seg_decode(seg_t) -> {bad, blank, nibble}.
//  Sub-module seg7_digit_capture:
//    - Stability counter and one-accept-per-dwell logic.
//    - Outputs accept pulse + slot index.
//  Top holds the shadow, mask, frame assembly and error flags.
// TESTING
//  1 Scan 4,3,2,1 into digits 3..0, 3 cycles each -> frame_valid one cycle after digit 0's
//    3rd sample; number_out=16'h4321, blank_mask=0.
//  2 Digit 2 held only 2 cycles then sel changes -> no accept; frame incomplete; no pulse
//    until digit 2 shown 3 cycles.
//  3 seg_in=7'b1010101 stable on digit 1 -> err_pattern=1, nibble1=4'hE;
//    clear_err -> 0 next cycle.
//  4 dig_sel=4'b0011 for 5 cycles -> err_sel=1, no accept.
//    dig_sel=0 gaps between digits -> no error, frame still completes.
//  5 Blank digits 3,2 + "07" -> number_out=16'hFF07, blank_mask=4'b1100.
//  6 rst_n pulsed low after 2 of 4 digits accepted -> outputs at reset values; next full
//    scan yields frame. Repeat identical frame with SEG7_DEC_CHANGE_ONLY_EN -> no 2nd pulse.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment encoding table and decode helper.
// Used by the display encoder and by seg7_frame_decoder.
package seg7_pkg;

  localparam int SEG_W = 7;
  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam logic [3:0] DIGIT_BAD = 4'hE;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_TABLE [0:9] = '{
    7'b1111110, 7'b1100000, 7'b1011101,
    7'b1111001, 7'b1100011, 7'b0111011,
    7'b0111111, 7'b1101000, 7'b1111111,
    7'b1111011
  };

  typedef struct packed {
    logic       bad;
    logic       blank;
    logic [3:0] nibble;
  } seg_dec_t;

  function automatic seg_dec_t seg_decode(
    input seg_t seg
  );
    seg_dec_t d;
    d.bad = 1'b1;
    d.blank = 1'b0;
    d.nibble = DIGIT_BAD;
    if (seg == '0) begin
      d.bad = 1'b0;
      d.blank = 1'b1;
      d.nibble = DIGIT_BLANK;
    end
    for (int i = 0; i < 10; i++) begin
      if (seg == SEG_TABLE[i]) begin
        d.bad = 1'b0;
        d.nibble = 4'(i);
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/seg7_digit_capture.sv
// Per-digit stability counter; emits one accept pulse per
// stable dwell together with the selected slot index.
module seg7_digit_capture
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int STABLE_CYCLES = 3,
  parameter int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SEG_W-1:0]  seg_in,
  input  logic [DIGITS-1:0] dig_sel,
  output logic              accept,
  output logic [IDX_W-1:0]  slot,
  output logic              multi_hot
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  seg_t              prev_seg_q, prev_seg_d;
  logic [DIGITS-1:0] prev_sel_q, prev_sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              one_hot;
  logic              same;

  always_comb begin
    one_hot = $onehot(dig_sel);
    multi_hot = (|dig_sel) && !one_hot;
    same = (seg_in == prev_seg_q) &&
           (dig_sel == prev_sel_q);
    prev_seg_d = seg_in;
    prev_sel_d = dig_sel;
    cnt_d = cnt_q;
    if (!one_hot) begin
      cnt_d = '0;
    end else if (!same) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end
    // saturation keeps a long dwell from accepting twice
    accept = one_hot && (cnt_d == CNT_MAX) &&
             !(same && (cnt_q == CNT_MAX));
    slot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_sel[i]) slot = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_seg_q <= '0;
      prev_sel_q <= '0;
      cnt_q <= '0;
    end else begin
      prev_seg_q <= prev_seg_d;
      prev_sel_q <= prev_sel_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg7_frame_decoder.sv
// Reconstructs the multiplexed 7-segment frame into BCD nibbles.
// Option SEG7_DEC_CHANGE_ONLY_EN: pulse frame_valid only on change.
module seg7_frame_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          seg_in,
  input  logic [DIGITS-1:0]   dig_sel,
  input  logic                clear_err,
  output logic [4*DIGITS-1:0] number_out,
  output logic [DIGITS-1:0]   blank_mask,
  output logic                frame_valid,
  output logic                err_pattern,
  output logic                err_sel
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic             accept;
  logic [IDX_W-1:0] slot;
  logic             multi_hot;
  seg_dec_t         dec;
  logic             full;

  logic [4*DIGITS-1:0] shadow_num_q, shadow_num_d;
  logic [DIGITS-1:0]   shadow_blank_q, shadow_blank_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic [4*DIGITS-1:0] number_q, number_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic                fv_q, fv_d;
  logic                err_pat_q, err_pat_d;
  logic                err_sel_q, err_sel_d;
`ifdef SEG7_DEC_CHANGE_ONLY_EN
  logic                first_q, first_d;
`endif

  seg7_digit_capture #(
    .DIGITS(DIGITS),
    .STABLE_CYCLES(STABLE_CYCLES),
    .IDX_W(IDX_W)
  ) u_capture (
    .clk(clk),
    .rst_n(rst_n),
    .seg_in(seg_in),
    .dig_sel(dig_sel),
    .accept(accept),
    .slot(slot),
    .multi_hot(multi_hot)
  );

  always_comb begin
    dec = seg_decode(seg_in);
    full = &mask_q;
    shadow_num_d = shadow_num_q;
    shadow_blank_d = shadow_blank_q;
    mask_d = full ? '0 : mask_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (accept && (slot == IDX_W'(i))) begin
        shadow_num_d[4*i +: 4] = dec.nibble;
        shadow_blank_d[i] = dec.blank;
        mask_d[i] = 1'b1;
      end
    end
    number_d = number_q;
    blank_d = blank_q;
    fv_d = 1'b0;
`ifdef SEG7_DEC_CHANGE_ONLY_EN
    first_d = first_q;
`endif
    if (full) begin
      number_d = shadow_num_q;
      blank_d = shadow_blank_q;
`ifdef SEG7_DEC_CHANGE_ONLY_EN
      fv_d = first_q ||
             (number_q != shadow_num_q) ||
             (blank_q != shadow_blank_q);
      first_d = 1'b0;
`else
      fv_d = 1'b1;
`endif
    end
    // a fresh error outranks a same-cycle clear
    err_pat_d = (accept && dec.bad) ||
                (err_pat_q && !clear_err);
    err_sel_d = multi_hot ||
                (err_sel_q && !clear_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_num_q <= '0;
      shadow_blank_q <= '1;
      mask_q <= '0;
      number_q <= '0;
      blank_q <= '1;
      fv_q <= 1'b0;
      err_pat_q <= 1'b0;
      err_sel_q <= 1'b0;
    end else begin
      shadow_num_q <= shadow_num_d;
      shadow_blank_q <= shadow_blank_d;
      mask_q <= mask_d;
      number_q <= number_d;
      blank_q <= blank_d;
      fv_q <= fv_d;
      err_pat_q <= err_pat_d;
      err_sel_q <= err_sel_d;
    end
  end

`ifdef SEG7_DEC_CHANGE_ONLY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) first_q <= 1'b1;
    else first_q <= first_d;
  end
`endif

  assign number_out = number_q;
  assign blank_mask = blank_q;
  assign frame_valid = fv_q;
  assign err_pattern = err_pat_q;
  assign err_sel = err_sel_q;

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Scoreboard bench for seg7_frame_decoder (4 digits, 3-sample dwell).
module tb_seg7_frame_decoder;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  dig_sel;
  logic        clear_err;
  logic [15:0] number_out;
  logic [3:0]  blank_mask;
  logic        frame_valid;
  logic        err_pattern;
  logic        err_sel;

  typedef struct {
    logic [15:0] num;
    logic [3:0]  blank;
  } frame_t;

  frame_t exp_q[$];
  int applied = 0;
  int miscompares = 0;
  int pulse_cnt = 0;

  localparam logic [6:0] ENC [0:9] = '{
    7'b1111110, 7'b1100000, 7'b1011101, 7'b1111001,
    7'b1100011, 7'b0111011, 7'b0111111, 7'b1101000,
    7'b1111111, 7'b1111011
  };
  localparam logic [6:0] BAD = 7'b1010101;
  localparam logic [6:0] BLK = 7'b0000000;

  seg7_frame_decoder #(
    .DIGITS(4),
    .STABLE_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .seg_in(seg_in),
    .dig_sel(dig_sel),
    .clear_err(clear_err),
    .number_out(number_out),
    .blank_mask(blank_mask),
    .frame_valid(frame_valid),
    .err_pattern(err_pattern),
    .err_sel(err_sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (frame_valid === 1'b1) pulse_cnt++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic show(input logic [3:0] sel,
                      input logic [6:0] seg,
                      input int n);
    dig_sel = sel;
    seg_in = seg;
    step(n);
  endtask

  // bounded wait; lat = cycles until frame_valid seen
  task automatic wait_frame(output int lat);
    lat = 0;
    while (frame_valid !== 1'b1 && lat < 20) begin
      step(1);
      lat++;
    end
  endtask

  task automatic test_reset;
    frame_t f;
    rst_n = 1'b0;
    seg_in = '0;
    dig_sel = '0;
    clear_err = 1'b0;
    step(2);
    applied++;
    if (number_out !== 16'h0 || blank_mask !== 4'hF ||
        frame_valid !== 1'b0 || err_pattern !== 1'b0 ||
        err_sel !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: num=%h blank=%b fv=%b ep=%b es=%b",
               number_out, blank_mask, frame_valid,
               err_pattern, err_sel);
    end
    rst_n = 1'b1;
    step(1);
    f.num = 16'h0;
    f.blank = 4'hF;
    applied++;
    if (number_out !== f.num || blank_mask !== f.blank) begin
      miscompares++;
      $display("FAIL reset_release: num=%h blank=%b",
               number_out, blank_mask);
    end
  endtask

  task automatic test_scan;
    frame_t f;
    int lat;
    show(4'b1000, ENC[4], 3);
    show(4'b0100, ENC[3], 3);
    show(4'b0010, ENC[2], 3);
    f.num = 16'h4321;
    f.blank = 4'b0000;
    exp_q.push_back(f);
    show(4'b0001, ENC[1], 3);
    wait_frame(lat);
    applied++;
    if (lat !== 1 || frame_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL scan_latency: got %0d cycles fv=%b want 1",
               lat, frame_valid);
    end
    f = exp_q.pop_front();
    applied++;
    if (number_out !== f.num || blank_mask !== f.blank) begin
      miscompares++;
      $display("FAIL scan_frame: num=%h blank=%b want %h %b",
               number_out, blank_mask, f.num, f.blank);
    end
    step(1);
    applied++;
    if (frame_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL scan_pulse_width: fv=%b want 0", frame_valid);
    end
    show(4'b0000, BLK, 1);
  endtask

  task automatic test_short_dwell;
    frame_t f;
    int lat;
    int p0;
    p0 = pulse_cnt;
    show(4'b1000, ENC[5], 3);
    show(4'b0100, ENC[6], 2);
    show(4'b0010, ENC[7], 3);
    show(4'b0001, ENC[8], 3);
    show(4'b0000, BLK, 3);
    applied++;
    if (pulse_cnt !== p0) begin
      miscompares++;
      $display("FAIL short_no_frame: pulses=%0d want %0d",
               pulse_cnt, p0);
    end
    f.num = 16'h5678;
    f.blank = 4'b0000;
    exp_q.push_back(f);
    show(4'b0100, ENC[6], 3);
    wait_frame(lat);
    applied++;
    if (lat !== 1 || frame_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL short_latency: got %0d cycles want 1", lat);
    end
    f = exp_q.pop_front();
    applied++;
    if (number_out !== f.num || blank_mask !== f.blank) begin
      miscompares++;
      $display("FAIL short_frame: num=%h blank=%b want %h %b",
               number_out, blank_mask, f.num, f.blank);
    end
    show(4'b0000, BLK, 1);
  endtask

  task automatic test_bad_pattern;
    frame_t f;
    int lat;
    show(4'b1000, ENC[1], 3);
    show(4'b0100, ENC[2], 3);
    show(4'b0010, BAD, 2);
    applied++;
    if (err_pattern !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_early: err_pattern=%b want 0", err_pattern);
    end
    step(1);
    applied++;
    if (err_pattern !== 1'b1) begin
      miscompares++;
      $display("FAIL bad_flag: err_pattern=%b want 1", err_pattern);
    end
    f.num = 16'h12E3;
    f.blank = 4'b0000;
    exp_q.push_back(f);
    show(4'b0001, ENC[3], 3);
    wait_frame(lat);
    f = exp_q.pop_front();
    applied++;
    if (frame_valid !== 1'b1 || number_out !== f.num ||
        blank_mask !== f.blank) begin
      miscompares++;
      $display("FAIL bad_frame: fv=%b num=%h blank=%b want %h %b",
               frame_valid, number_out, blank_mask, f.num, f.blank);
    end
    show(4'b0000, BLK, 2);
    applied++;
    if (err_pattern !== 1'b1) begin
      miscompares++;
      $display("FAIL bad_sticky: err_pattern=%b want 1", err_pattern);
    end
    clear_err = 1'b1;
    step(1);
    clear_err = 1'b0;
    applied++;
    if (err_pattern !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_clear: err_pattern=%b want 0", err_pattern);
    end
  endtask

  task automatic test_sel_errors;
    frame_t f;
    int lat;
    int p0;
    p0 = pulse_cnt;
    show(4'b0011, ENC[8], 5);
    applied++;
    if (err_sel !== 1'b1 || pulse_cnt !== p0) begin
      miscompares++;
      $display("FAIL multi_hot: err_sel=%b pulses=%0d want 1 %0d",
               err_sel, pulse_cnt, p0);
    end
    clear_err = 1'b1;
    step(1);
    applied++;
    if (err_sel !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_vs_new: err_sel=%b want 1", err_sel);
    end
    dig_sel = 4'b0000;
    step(1);
    clear_err = 1'b0;
    applied++;
    if (err_sel !== 1'b0) begin
      miscompares++;
      $display("FAIL sel_clear: err_sel=%b want 0", err_sel);
    end
    show(4'b1000, ENC[9], 3);
    show(4'b0000, BLK, 2);
    show(4'b0100, ENC[8], 3);
    show(4'b0000, BLK, 2);
    show(4'b0010, ENC[7], 3);
    show(4'b0000, BLK, 2);
    f.num = 16'h9876;
    f.blank = 4'b0000;
    exp_q.push_back(f);
    show(4'b0001, ENC[6], 3);
    wait_frame(lat);
    f = exp_q.pop_front();
    applied++;
    if (lat !== 1 || number_out !== f.num ||
        blank_mask !== f.blank) begin
      miscompares++;
      $display("FAIL gap_frame: lat=%0d num=%h blank=%b want %h %b",
               lat, number_out, blank_mask, f.num, f.blank);
    end
    applied++;
    if (err_sel !== 1'b0 || err_pattern !== 1'b0) begin
      miscompares++;
      $display("FAIL gap_errors: err_sel=%b err_pattern=%b want 0 0",
               err_sel, err_pattern);
    end
    show(4'b0000, BLK, 1);
  endtask

  task automatic test_blank;
    frame_t f;
    int lat;
    show(4'b1000, BLK, 3);
    show(4'b0100, BLK, 3);
    show(4'b0010, ENC[0], 3);
    f.num = 16'hFF07;
    f.blank = 4'b1100;
    exp_q.push_back(f);
    show(4'b0001, ENC[7], 3);
    wait_frame(lat);
    f = exp_q.pop_front();
    applied++;
    if (frame_valid !== 1'b1 || number_out !== f.num ||
        blank_mask !== f.blank) begin
      miscompares++;
      $display("FAIL blank_frame: fv=%b num=%h blank=%b want %h %b",
               frame_valid, number_out, blank_mask, f.num, f.blank);
    end
    show(4'b0000, BLK, 1);
  endtask

  task automatic test_reset_mid;
    frame_t f;
    int lat;
    int p0;
    show(4'b1000, ENC[9], 3);
    show(4'b0100, ENC[9], 3);
    rst_n = 1'b0;
    #1;
    applied++;
    if (number_out !== 16'h0 || blank_mask !== 4'hF ||
        frame_valid !== 1'b0 || err_pattern !== 1'b0 ||
        err_sel !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: num=%h blank=%b fv=%b",
               number_out, blank_mask, frame_valid);
    end
    dig_sel = 4'b0000;
    step(1);
    rst_n = 1'b1;
    step(1);
    p0 = pulse_cnt;
    show(4'b0010, ENC[3], 3);
    show(4'b0001, ENC[4], 3);
    show(4'b0000, BLK, 3);
    applied++;
    if (pulse_cnt !== p0) begin
      miscompares++;
      $display("FAIL mid_discard: pulses=%0d want %0d", pulse_cnt, p0);
    end
    show(4'b1000, ENC[1], 3);
    f.num = 16'h1234;
    f.blank = 4'b0000;
    exp_q.push_back(f);
    show(4'b0100, ENC[2], 3);
    wait_frame(lat);
    f = exp_q.pop_front();
    applied++;
    if (lat !== 1 || number_out !== f.num ||
        blank_mask !== f.blank) begin
      miscompares++;
      $display("FAIL post_reset_frame: lat=%0d num=%h want %h",
               lat, number_out, f.num);
    end
    show(4'b0000, BLK, 1);
    p0 = pulse_cnt;
    show(4'b1000, ENC[1], 3);
    show(4'b0100, ENC[2], 3);
    show(4'b0010, ENC[3], 3);
`ifdef SEG7_DEC_CHANGE_ONLY_EN
    show(4'b0001, ENC[4], 3);
    show(4'b0000, BLK, 5);
    applied++;
    if (pulse_cnt !== p0) begin
      miscompares++;
      $display("FAIL repeat_silent: pulses=%0d want %0d",
               pulse_cnt, p0);
    end
`else
    f.num = 16'h1234;
    f.blank = 4'b0000;
    exp_q.push_back(f);
    show(4'b0001, ENC[4], 3);
    wait_frame(lat);
    f = exp_q.pop_front();
    applied++;
    if (frame_valid !== 1'b1 || number_out !== f.num) begin
      miscompares++;
      $display("FAIL repeat_frame: fv=%b num=%h want 1 %h",
               frame_valid, number_out, f.num);
    end
    show(4'b0000, BLK, 2);
`endif
    applied++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard_left: %0d entries want 0",
               exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_short_dwell();
    test_bad_pattern();
    test_sel_errors();
    test_blank();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

endmodule
